// File: rtl/mul_csa_seq.sv
// mul_csa_seq -- iterative unsigned multiplier for the integer ALU.
//
// Folds two partial products per cycle into a carry-save accumulator
// (sum, carry) through a row of 2*WIDTH 4:2 compressors, then resolves the
// accumulator with a single carry-propagate add. The 2*WIDTH product is
// presented over a valid/ready handshake and held until it is consumed.
//
// Optional build macro:
//   MUL_EARLY_EXIT_EN  leave COMPRESS as soon as the remaining multiplier
//                      bits are all zero. The result is unchanged; only the
//                      latency shrinks for small multipliers.
//
// Parameters:
//   WIDTH        operand width in bits (even, >= 4)
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE only)
//   a_i          multiplicand, unsigned
//   b_i          multiplier, unsigned
//   abort_i      synchronous cancel of the current operation
//   out_valid_o  product valid (DONE)
//   out_ready_i  consumer accepts product
//   product_o    a*b, changes only in RESOLVE or on reset
//   busy_o       operation in progress (state != IDLE)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for operands, in_ready_o=1
// COMPRESS | one 4:2 compression step per cycle, WIDTH/2 steps
// RESOLVE  | carry-propagate add S + C into product_o
// DONE     | out_valid_o=1, product held until out_ready_i

module mul_csa_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               abort_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    RESOLVE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state;
  logic [PW-1:0]     a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PW-1:0]     s_q;
  logic [PW-1:0]     c_q;
  logic [CNT_W-1:0]  count;

  // Compressor row datapath
  logic [PW-1:0]     pp0;
  logic [PW-1:0]     pp1;
  logic [PW-1:0]     t_vec;
  logic [PW-2:0]     cout_vec;
  logic [PW-1:0]     cin_vec;
  logic [PW-1:0]     csa_sum;
  logic [PW-2:0]     csa_carry;
  logic [WIDTH-1:0]  b_next;
  logic              last_step;

  assign pp0 = b_q[0] ? a_q : '0;
  assign pp1 = b_q[1] ? {a_q[PW-2:0], 1'b0} : '0;

  // Each 4:2 cell takes S[k], C[k], pp0[k], pp1[k] plus the lateral carry
  // from column k-1. The lateral carry-out is the majority of C, pp0, pp1,
  // so it never depends on the incoming lateral carry: no ripple chain.
  // Column PW-1 lateral carry-out and cell carry fall off the top (mod 2^PW).
  assign t_vec     = c_q ^ pp0 ^ pp1;
  assign cout_vec  = (c_q[PW-2:0] & pp0[PW-2:0]) |
                     (c_q[PW-2:0] & pp1[PW-2:0]) |
                     (pp0[PW-2:0] & pp1[PW-2:0]);
  assign cin_vec   = {cout_vec, 1'b0};
  assign csa_sum   = s_q ^ t_vec ^ cin_vec;
  assign csa_carry = (s_q[PW-2:0] & t_vec[PW-2:0]) |
                     (s_q[PW-2:0] & cin_vec[PW-2:0]) |
                     (t_vec[PW-2:0] & cin_vec[PW-2:0]);

  assign b_next = b_q >> 2;

`ifdef MUL_EARLY_EXIT_EN
  // Nothing left to fold once the shifted multiplier is zero.
  assign last_step = (count == LAST_STEP) || (b_next == '0);
`else
  assign last_step = (count == LAST_STEP);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      c_q         <= '0;
      count       <= '0;
      product_o   <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && !abort_i) begin
            a_q        <= {{WIDTH{1'b0}}, a_i};
            b_q        <= b_i;
            s_q        <= '0;
            c_q        <= '0;
            count      <= '0;
            state      <= COMPRESS;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end

        COMPRESS: begin
          if (abort_i) begin
            state      <= IDLE;
            in_ready_o <= 1'b1;
            busy_o     <= 1'b0;
          end else begin
            s_q   <= csa_sum;
            c_q   <= {csa_carry, 1'b0};
            a_q   <= a_q << 2;
            b_q   <= b_next;
            count <= count + 1'b1;
            if (last_step) begin
              state <= RESOLVE;
            end
          end
        end

        RESOLVE: begin
          if (abort_i) begin
            state      <= IDLE;
            in_ready_o <= 1'b1;
            busy_o     <= 1'b0;
          end else begin
            product_o   <= s_q + c_q;
            state       <= DONE;
            out_valid_o <= 1'b1;
          end
        end

        DONE: begin
          // Abort takes precedence over the consumer handshake.
          if (abort_i || out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_csa_seq.sv
module tb_mul_csa_seq;

  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           abort_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [2*W-1:0] product_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  mul_csa_seq #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .abort_i     (abort_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Edges from accept to out_valid_o for a given multiplier.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int m;
    int steps;
    m = -1;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    steps = (m < 0) ? 0 : (m + 2) / 2;
    if (steps < 1) steps = 1;
    return steps + 1;
`else
    return W / 2 + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] p, output int lat);
    chk("ready_before_accept", 64'(in_ready_o), 64'd1);
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("busy_after_accept", 64'(busy_o), 64'd1);
    lat = 0;
    while (out_valid_o !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    p = product_o;
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat;
    bit seen;

    vecs[0]  = '{32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2]  = '{32'd5,        32'd3,        64'd15};
    vecs[3]  = '{32'd5,        32'h80000000, 64'h0000000280000000};
    vecs[4]  = '{32'd0,        32'h00001234, 64'd0};
    vecs[5]  = '{32'h00001234, 32'd0,        64'd0};
    vecs[6]  = '{32'd1,        32'd1,        64'd1};
    vecs[7]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[8]  = '{32'hDEADBEEF, 32'd1,        64'h00000000DEADBEEF};
    vecs[9]  = '{32'd3,        32'h80000000, 64'h0000000180000000};
    vecs[10] = '{32'hFFFFFFFF, 32'd2,        64'h00000001FFFFFFFE};
    vecs[11] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[12] = '{32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF80000000};
    vecs[13] = '{32'd1000,     32'd1000,     64'h00000000000F4240};

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    a_i = '0;
    b_i = '0;
    abort_i = 1'b0;
    out_ready_i = 1'b1;

    // Reset held three cycles
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_product", product_o, 64'd0);

    // Abort with operands offered in IDLE: not accepted
    a_i = 32'd9;
    b_i = 32'd9;
    in_valid_i = 1'b1;
    abort_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    abort_i = 1'b0;
    chk("idle_abort_busy", 64'(busy_o), 64'd0);
    chk("idle_abort_ready", 64'(in_ready_o), 64'd1);

    // Abort on the 8th COMPRESS cycle
    a_i = 32'hFFFFFFFF;
    b_i = 32'hFFFFFFFF;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (7) tick();
    chk("compress_busy_before_abort", 64'(busy_o), 64'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_in_ready", 64'(in_ready_o), 64'd1);
    chk("abort_out_valid", 64'(out_valid_o), 64'd0);
    chk("abort_product", product_o, 64'd0);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid_o !== 1'b0) seen = 1;
    end
    chk("abort_no_stale_valid", 64'(seen), 64'd0);

    // Table of directed vectors, consumer always ready
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, p, lat);
      chk($sformatf("vec%0d_product", i), p, vecs[i].p);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
      tick();
      chk($sformatf("vec%0d_valid_drop", i), 64'(out_valid_o), 64'd0);
      chk($sformatf("vec%0d_ready_back", i), 64'(in_ready_o), 64'd1);
    end

    // Backpressure: 7*6 held for five cycles, in_valid pulse ignored
    out_ready_i = 1'b0;
    run_op(32'd7, 32'd6, p, lat);
    chk("bp_latency", 64'(lat), 64'(exp_lat(32'd6)));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_i = 32'd11;
        b_i = 32'd13;
        in_valid_i = 1'b1;
      end
      tick();
      in_valid_i = 1'b0;
      chk($sformatf("bp_hold%0d_product", i), product_o, 64'd42);
      chk($sformatf("bp_hold%0d_valid", i), 64'(out_valid_o), 64'd1);
      chk($sformatf("bp_hold%0d_ready", i), 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    tick();
    chk("bp_release_valid", 64'(out_valid_o), 64'd0);
    chk("bp_release_ready", 64'(in_ready_o), 64'd1);
    chk("bp_release_busy", 64'(busy_o), 64'd0);
    chk("bp_release_product", product_o, 64'd42);

    // Abort in DONE wins over the handshake, product retained
    out_ready_i = 1'b0;
    run_op(32'd5, 32'd3, p, lat);
    chk("done_abort_pre_product", p, 64'd15);
    abort_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("done_abort_valid", 64'(out_valid_o), 64'd0);
    chk("done_abort_busy", 64'(busy_o), 64'd0);
    chk("done_abort_product", product_o, 64'd15);

    // Reset during RESOLVE
    a_i = 32'hFFFFFFFF;
    b_i = 32'hFFFFFFFF;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (W / 2) tick();
    chk("resolve_busy", 64'(busy_o), 64'd1);
    chk("resolve_valid", 64'(out_valid_o), 64'd0);
    rst_i = 1'b1;
    tick();
    chk("midrst_product", product_o, 64'd0);
    chk("midrst_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_ready", 64'(in_ready_o), 64'd1);
    rst_i = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid_o !== 1'b0) seen = 1;
    end
    chk("midrst_no_stale_valid", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_csa_seq.md
Name: mul_csa_seq

Overview:
- Iterative unsigned integer multiplier controller for the integer ALU.
- Sequences a row of 2*WIDTH 4:2 compressors that fold two partial products per cycle into a carry-save accumulator (sum, carry).
- Resolves the accumulator with one carry-propagate add.
- Presents the 2*WIDTH product over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- in_valid_i  input  1  operands valid
- in_ready_o  output  1  block can accept operands
- a_i  input  WIDTH  multiplicand, unsigned
- b_i  input  WIDTH  multiplier, unsigned
- abort_i  input  1  synchronous cancel of the current operation
- out_valid_o  output  1  product valid
- out_ready_i  input  1  consumer accepts product
- product_o  output  2*WIDTH  a*b
- busy_o  output  1  operation in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: state=IDLE; in_ready_o=1, out_valid_o=0, busy_o=0, product_o=0; all internal registers cleared.
- Reset has priority over every other input, including mid-operation; the operation is discarded.
- States: IDLE, COMPRESS, RESOLVE, DONE.
- IDLE
  - in_ready_o=1.
  - When in_valid_i=1 and abort_i=0: latch A=zero-extend(a_i) to 2*WIDTH and B=b_i; clear S, C and count; go to COMPRESS.
  - When in_valid_i=1 and abort_i=1: abort wins and the operands are not accepted.
- COMPRESS (one step per cycle)
  - pp0 = B[0] ? A : 0.
  - pp1 = B[1] ? (A<<1) : 0, truncated to 2*WIDTH.
  - Per column k: the compressor inputs are S[k], C[k], pp0[k] and pp1[k].
  - Carry-in chain: column 0 carry-in = 0; column k carry-in = column k-1 carry-out (the majority of inputs 2..4).
  - New S = compressor sums.
  - New C = compressor carries shifted left by 1, bit 0 = 0.
  - The carry and carry-out of column 2*WIDTH-1 are discarded (modulo 2^(2*WIDTH)).
  - Then A<<=2, B>>=2, count++.
  - After WIDTH/2 steps, go to RESOLVE.
- RESOLVE: product_o <= S + C (mod 2^(2*WIDTH)); go to DONE.
- DONE
  - out_valid_o=1.
  - product_o is held stable until out_ready_i=1, then the block goes to IDLE.
  - There is no same-cycle accept of new operands in DONE.
- Latency: out_valid_o rises WIDTH/2+1 clock edges after the accepting edge (17 for WIDTH=32).
- in_ready_o=1 only in IDLE. in_valid_i is ignored in every other state.
- abort_i
  - In COMPRESS, RESOLVE or DONE: go to IDLE on the next edge, out_valid_o=0, product_o unchanged.
  - Abort has priority over the out_ready_i handshake in DONE.
- product_o changes only in RESOLVE or on reset.
- Boundary cases: a_i=0 or b_i=0 gives product 0 with full latency, unless the optional feature is enabled.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in COMPRESS, if the post-shift B is zero, go directly to RESOLVE.
  - Latency becomes max(1, ceil(msb_index(b)+1)/2) + 1 edges.
  - b_i=0 or b_i=1 gives 2 edges.
  - The result is identical to the fixed-latency result.
- Undefined: fixed WIDTH/2+1 latency for all operands; no early-exit logic.

Test Plan:
- Reset: hold rst_i 3 cycles, then release -> in_ready_o=1, out_valid_o=0, busy_o=0, product_o=0.
- WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready_i=1 -> product_o=0xFFFFFFFE00000001; out_valid_o high exactly 17 edges after accept, for one cycle; then in_ready_o=1.
- Backpressure: a=7, b=6, out_ready_i=0 for 5 cycles after out_valid_o rises.
  - product_o=42 held stable; in_ready_o=0; a pulse on in_valid_i is ignored.
  - Raising out_ready_i -> IDLE on the next edge.
- Abort: assert abort_i on the 8th COMPRESS cycle -> IDLE on the next edge, no out_valid_o. A following a=0x12345678, b=0x9ABCDEF0 -> 0x0B00EA4E242D2080.
- Reset mid-operation: rst_i during RESOLVE -> all outputs at reset values on the next edge, and no stale out_valid_o.
- Early exit: b=3, a=5.
  - With MUL_EARLY_EXIT_EN: product 15 with out_valid_o 2 edges after accept.
  - Without the macro: 15 after 17 edges.
  - b=0x80000000 gives 17 edges in both builds.
